// File: rtl/snake_head_mover.sv
// Snake head motion: samples the one-hot direcao once per game tick, rejects invalid or
// reversing requests and steps the head one cell. Define SNAKE_WRAP_EN for toroidal wrap.
module snake_head_mover #(
    parameter int GRID_W   = 16,
    parameter int GRID_H   = 16,
    parameter int X_W      = 4,
    parameter int Y_W      = 4,
    parameter int TICK_DIV = 25000000
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           enable,
    input  logic           restart,
    input  logic [3:0]     direcao,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic [3:0]     dir_atual,
    output logic           step,
    output logic           game_over
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [X_W-1:0] X_MAX   = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX   = Y_W'(GRID_H - 1);
    localparam logic [X_W-1:0] X_RST   = X_W'(GRID_W / 2);
    localparam logic [Y_W-1:0] Y_RST   = Y_W'(GRID_H / 2);

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [3:0]      cand;
    logic [X_W-1:0]  nx;
    logic [Y_W-1:0]  ny;
`ifndef SNAKE_WRAP_EN
    logic            wall;
`endif

    // Reverse of a one-hot code is the code with its two halves swapped.
    always_comb begin
        cand = dir_atual;
        if ($onehot(direcao) && (direcao != {dir_atual[1:0], dir_atual[3:2]}))
            cand = direcao;
        nx = head_x;
        ny = head_y;
`ifndef SNAKE_WRAP_EN
        wall = 1'b0;
`endif
        case (cand)
            4'b0001: begin
                if (head_y == '0) begin
`ifdef SNAKE_WRAP_EN
                    ny = Y_MAX;
`else
                    wall = 1'b1;
`endif
                end else ny = head_y - Y_W'(1);
            end
            4'b0010: begin
                if (head_x == '0) begin
`ifdef SNAKE_WRAP_EN
                    nx = X_MAX;
`else
                    wall = 1'b1;
`endif
                end else nx = head_x - X_W'(1);
            end
            4'b0100: begin
                if (head_y == Y_MAX) begin
`ifdef SNAKE_WRAP_EN
                    ny = '0;
`else
                    wall = 1'b1;
`endif
                end else ny = head_y + Y_W'(1);
            end
            4'b1000: begin
                if (head_x == X_MAX) begin
`ifdef SNAKE_WRAP_EN
                    nx = '0;
`else
                    wall = 1'b1;
`endif
                end else nx = head_x + X_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            head_x    <= X_RST;
            head_y    <= Y_RST;
            dir_atual <= 4'b0001;
            step      <= 1'b0;
            game_over <= 1'b0;
        end else begin
            step <= 1'b0;
            if (restart) begin
                state     <= IDLE;
                cnt       <= '0;
                head_x    <= X_RST;
                head_y    <= Y_RST;
                dir_atual <= 4'b0001;
                game_over <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (enable) begin
                            state <= RUN;
                            cnt   <= '0;
                        end
                    end
                    RUN: begin
                        if (enable) begin
                            if (cnt == CNT_MAX) begin
                                cnt <= '0;
`ifdef SNAKE_WRAP_EN
                                head_x    <= nx;
                                head_y    <= ny;
                                dir_atual <= cand;
                                step      <= 1'b1;
`else
                                // A fatal step freezes the head at its last legal cell.
                                if (wall) begin
                                    state     <= DEAD;
                                    game_over <= 1'b1;
                                end else begin
                                    head_x    <= nx;
                                    head_y    <= ny;
                                    dir_atual <= cand;
                                    step      <= 1'b1;
                                end
`endif
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snake_head_mover.sv
// Bench for snake_head_mover: vector table, corner-case sequences and random stimulus
// checked cycle by cycle against an integer-grid reference model.
module tb_snake_head_mover;

    localparam int GW   = 8;
    localparam int GH   = 8;
    localparam int TICK = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       restart;
    logic [3:0] direcao;
    logic [2:0] head_x;
    logic [2:0] head_y;
    logic [3:0] dir_atual;
    logic       step;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    snake_head_mover #(
        .GRID_W(GW), .GRID_H(GH), .X_W(3), .Y_W(3), .TICK_DIV(TICK)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .restart(restart),
        .direcao(direcao), .head_x(head_x), .head_y(head_y),
        .dir_atual(dir_atual), .step(step), .game_over(game_over)
    );

    always #5 clock = ~clock;

    // Reference model: integer coordinates and a count of enabled running cycles.
    bit         m_run, m_dead, m_step, m_go;
    int         m_cnt, m_x, m_y;
    logic [3:0] m_dir;

    task automatic model_reset();
        m_run = 0; m_dead = 0; m_step = 0; m_go = 0;
        m_cnt = 0; m_x = GW / 2; m_y = GH / 2; m_dir = 4'b0001;
    endtask

    function automatic void vec(input logic [3:0] d, output int dx, output int dy);
        dx = 0; dy = 0;
        if (d == 4'b0001) dy = -1;
        if (d == 4'b0010) dx = -1;
        if (d == 4'b0100) dy = 1;
        if (d == 4'b1000) dx = 1;
    endfunction

    task automatic model_step(input logic [3:0] d);
        int dx, dy, cx, cy, nx, ny;
        logic [3:0] c;
        vec(d, dx, dy);
        vec(m_dir, cx, cy);
        c = m_dir;
        if ($countones(d) == 1 && !(dx == -cx && dy == -cy)) c = d;
        vec(c, dx, dy);
        nx = m_x + dx;
        ny = m_y + dy;
        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
`ifdef SNAKE_WRAP_EN
            nx = (nx + GW) % GW;
            ny = (ny + GH) % GH;
`else
            m_run = 0; m_dead = 1; m_go = 1;
            return;
`endif
        end
        m_x = nx; m_y = ny; m_dir = c; m_step = 1;
    endtask

    task automatic model_edge(input bit en, input bit rs, input logic [3:0] d);
        m_step = 0;
        if (rs) model_reset();
        else if (!m_run && !m_dead) begin
            if (en) begin m_run = 1; m_cnt = 0; end
        end else if (m_run && en) begin
            m_cnt++;
            if (m_cnt == TICK) begin
                m_cnt = 0;
                model_step(d);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".head_x"}, 32'(head_x), 32'(m_x));
        chk({tag, ".head_y"}, 32'(head_y), 32'(m_y));
        chk({tag, ".dir_atual"}, 32'(dir_atual), 32'(m_dir));
        chk({tag, ".step"}, 32'(step), 32'(m_step));
        chk({tag, ".game_over"}, 32'(game_over), 32'(m_go));
    endtask

    task automatic tick(input bit en, input bit rs, input logic [3:0] d, input string tag);
        enable = en; restart = rs; direcao = d;
        @(posedge clock);
        model_edge(en, rs, d);
        #1;
        chk_model(tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".head_x"}, 32'(head_x), 4);
        chk({tag, ".head_y"}, 32'(head_y), 4);
        chk({tag, ".dir_atual"}, 32'(dir_atual), 1);
        chk({tag, ".step"}, 32'(step), 0);
        chk({tag, ".game_over"}, 32'(game_over), 0);
    endtask

    typedef struct {
        logic [3:0] d;
        int         ex;
        int         ey;
        logic [3:0] edir;
        bit         ego;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{4'b0001, 4, 3, 4'b0001, 0};
        tbl[1] = '{4'b0100, 4, 2, 4'b0001, 0};  // reverse rejected
        tbl[2] = '{4'b1000, 5, 2, 4'b1000, 0};
        tbl[3] = '{4'b0011, 6, 2, 4'b1000, 0};  // multi-hot ignored
        tbl[4] = '{4'b0000, 7, 2, 4'b1000, 0};  // no request
        tbl[5] = '{4'b0001, 7, 1, 4'b0001, 0};
        tbl[6] = '{4'b0001, 7, 0, 4'b0001, 0};
`ifdef SNAKE_WRAP_EN
        tbl[7] = '{4'b0001, 7, 7, 4'b0001, 0};
`else
        tbl[7] = '{4'b0001, 7, 0, 4'b0001, 1};
`endif

        reset_n = 1'b0; enable = 1'b0; restart = 1'b0; direcao = 4'b0001;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        chk_reset_vals("reset");

        // Table: enter RUN, then each entry is 3 garbage cycles plus its step edge.
        tick(1, 0, 4'b0001, "enter");
        foreach (tbl[i]) begin
            for (int k = 0; k < TICK - 1; k++) begin
                tick(1, 0, 4'($urandom), "between");
                chk("no_step_between", 32'(step), 0);
            end
            tick(1, 0, tbl[i].d, "tbl");
            chk("tbl.head_x", 32'(head_x), 32'(tbl[i].ex));
            chk("tbl.head_y", 32'(head_y), 32'(tbl[i].ey));
            chk("tbl.dir_atual", 32'(dir_atual), 32'(tbl[i].edir));
            chk("tbl.game_over", 32'(game_over), 32'(tbl[i].ego));
            chk("tbl.step", 32'(step), tbl[i].ego ? 0 : 1);
        end

        // Restart out of DEAD (or RUN with wrap) on what would be a step edge.
        tick(1, 1, 4'b1000, "restart_dead");
        chk_reset_vals("restart_dead");
        repeat (2) begin
            tick(1, 0, 4'b1000, "idle_hold");
            chk("idle_hold.game_over", 32'(game_over), 0);
        end

        // Restart in RUN at count TICK-1 beats the step.
        tick(1, 1, 4'b0001, "rs0");
        tick(1, 0, 4'b1000, "enter2");
        repeat (TICK - 1) tick(1, 0, 4'b1000, "cnt");
        tick(1, 1, 4'b1000, "restart_run");
        chk_reset_vals("restart_run");

        // Pause at count 2 for 10 cycles, step lands 2 cycles after resume.
        tick(1, 0, 4'b0001, "enter3");
        repeat (2) tick(1, 0, 4'b0001, "pre_pause");
        for (int k = 0; k < 10; k++) begin
            tick(0, 0, 4'b0001, "paused");
            chk("paused.step", 32'(step), 0);
        end
        tick(1, 0, 4'b0001, "resume1");
        chk("resume1.step", 32'(step), 0);
        tick(1, 0, 4'b0001, "resume2");
        chk("resume2.step", 32'(step), 1);
        chk("resume2.head_y", 32'(head_y), 3);

        // Async reset at count 3 clears immediately and suppresses the step.
        repeat (TICK - 1) tick(1, 0, 4'b0010, "to_cnt3");
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_reset_vals("async_reset");
        @(posedge clock);
        #1;
        chk_reset_vals("reset_held");
        reset_n = 1'b1;
        tick(1, 0, 4'b0010, "after_reset");
        chk("after_reset.step", 32'(step), 0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] d;
            bit en, rs;
            en = ($urandom_range(0, 9) != 0);
            rs = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 3) != 0) d = 4'(1 << $urandom_range(0, 3));
            else d = 4'($urandom);
            tick(en, rs, d, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
